// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and transmitter, drained through a start/busy handshake.
// Optional overflow reporting (ovf_sticky, ovf_cnt) is enabled by defining UART_FIFO_OVF_EN.
module uart_rx_fifo #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_int,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [ADDR_W:0]   fifo_count,
  output logic              fifo_empty,
  output logic              fifo_full
`ifdef UART_FIFO_OVF_EN
  ,
  output logic              ovf_sticky,
  output logic [7:0]        ovf_cnt
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t            state;
  logic              rx_int_d;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [15:0]       hi_timer;
  logic [DATA_W-1:0] mem [DEPTH];

  logic push_seen;
  logic pop;
  logic push;

  assign fifo_count = count;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);

  // A full FIFO still accepts a byte when a pop frees a slot at the same edge.
  assign push_seen = rx_int_d & ~rx_int;
  assign pop       = (state == IDLE) & ~fifo_empty & ~tx_busy;
  assign push      = push_seen & (~fifo_full | pop);

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rx_int_d <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      hi_timer <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else begin
      rx_int_d <= rx_int;
      tx_start <= 1'b0;

      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (push && !pop) begin
        count <= count + (ADDR_W + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (ADDR_W + 1)'(1);
      end

      // A transmitter that never raises busy releases the FSM after 65536 WAIT_HI cycles.
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= mem[rd_ptr];
            state   <= START;
          end
        end
        START: begin
          tx_start <= 1'b1;
          hi_timer <= '0;
          state    <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy) begin
            state <= WAIT_LO;
          end else if (hi_timer == 16'hFFFF) begin
            state <= IDLE;
          end else begin
            hi_timer <= hi_timer + 16'd1;
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_FIFO_OVF_EN
  logic drop;

  assign drop = push_seen & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      ovf_cnt    <= '0;
    end else if (drop) begin
      ovf_sticky <= 1'b1;
      if (ovf_cnt != 8'hFF) begin
        ovf_cnt <= ovf_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table-driven push vectors plus hand-written drain, wrap, reset and timeout sequences.
module tb_uart_rx_fifo;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef struct {
    logic [7:0] data;
    logic [4:0] exp_count;
    logic       exp_full;
    logic       exp_empty;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_int = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic [ADDR_W:0]   fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
`ifdef UART_FIFO_OVF_EN
  logic              ovf_sticky;
  logic [7:0]        ovf_cnt;
`endif

  logic force_busy = 1'b0;
  logic model_busy = 1'b0;
  logic model_en = 1'b0;
  int   busy_len = 100;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [7:0] start_log[$];
  int   start_cyc[$];

  assign tx_busy = force_busy | model_busy;

  uart_rx_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_int     (rx_int),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full)
`ifdef UART_FIFO_OVF_EN
    ,
    .ovf_sticky (ovf_sticky),
    .ovf_cnt    (ovf_cnt)
`endif
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (tx_start) begin
      start_log.push_back(tx_data);
      start_cyc.push_back(cyc);
    end
  end

  // Transmitter model: a sampled tx_start keeps busy high for busy_len cycles.
  always @(posedge clk) begin
    if (model_en && tx_start && !model_busy) begin
      #1 model_busy = 1'b1;
      repeat (busy_len) @(posedge clk);
      #1 model_busy = 1'b0;
    end
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    @(negedge clk);
    rx_data = data;
    rx_int  = 1'b1;
    repeat (10) @(negedge clk);
    rx_int = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_log(input int n, input int limit);
    for (int i = 0; i < limit && start_log.size() < n; i++) @(negedge clk);
  endtask

  function automatic logic [7:0] log_at(input int idx);
    if (idx < start_log.size()) return start_log[idx];
    return 8'hxx;
  endfunction

  initial begin
    vec_t burst_vecs[5];
    vec_t full_vecs[18];
    int base;
    int c_push;
    int k;
    int gap;

    burst_vecs[0] = '{8'h01, 5'd1, 1'b0, 1'b0};
    burst_vecs[1] = '{8'h02, 5'd2, 1'b0, 1'b0};
    burst_vecs[2] = '{8'h03, 5'd3, 1'b0, 1'b0};
    burst_vecs[3] = '{8'h04, 5'd4, 1'b0, 1'b0};
    burst_vecs[4] = '{8'h05, 5'd5, 1'b0, 1'b0};
    for (int i = 0; i < 18; i++) begin
      full_vecs[i] = '{8'(8'h10 + i), (i < 16) ? 5'(i + 1) : 5'd16, (i >= 15), 1'b0};
    end

    // Reset state
    do_reset();
    checkOutput("reset_count", 32'(fifo_count), 0);
    checkOutput("reset_empty", 32'(fifo_empty), 1);
    checkOutput("reset_full", 32'(fifo_full), 0);
    checkOutput("reset_tx_start", 32'(tx_start), 0);
    checkOutput("reset_tx_data", 32'(tx_data), 0);
`ifdef UART_FIFO_OVF_EN
    checkOutput("reset_ovf_sticky", 32'(ovf_sticky), 0);
    checkOutput("reset_ovf_cnt", 32'(ovf_cnt), 0);
`endif

    // Single byte with push-to-start latency
    model_en = 1'b1;
    busy_len = 100;
    base = start_log.size();
    applyStimulus(8'h5A);
    c_push = cyc;
    checkOutput("t1_count_after_push", 32'(fifo_count), 1);
    k = 0;
    while (!tx_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("t1_start_latency", cyc - c_push, 2);
    checkOutput("t1_tx_data", 32'(tx_data), 32'h5A);
    @(negedge clk);
    checkOutput("t1_start_width", 32'(tx_start), 0);
    repeat (120) @(negedge clk);
    checkOutput("t1_start_count", start_log.size() - base, 1);
    checkOutput("t1_count_final", 32'(fifo_count), 0);
    checkOutput("t1_empty_final", 32'(fifo_empty), 1);

    // Burst of five while the transmitter is busy, then ordered drain
    do_reset();
    busy_len = 20;
    force_busy = 1'b1;
    base = start_log.size();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(burst_vecs[i].data);
      checkOutput($sformatf("t2_count_%0d", i), 32'(fifo_count), 32'(burst_vecs[i].exp_count));
      checkOutput($sformatf("t2_empty_%0d", i), 32'(fifo_empty), 32'(burst_vecs[i].exp_empty));
    end
    checkOutput("t2_no_start", start_log.size() - base, 0);
    force_busy = 1'b0;
    wait_log(base + 5, 1000);
    repeat (30) @(negedge clk);
    checkOutput("t2_drain_count", start_log.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t2_order_%0d", i), 32'(log_at(base + i)), 32'(burst_vecs[i].data));
    end

    // Fill past capacity: the last two bytes are dropped
    do_reset();
    force_busy = 1'b1;
    base = start_log.size();
    for (int i = 0; i < 18; i++) begin
      applyStimulus(full_vecs[i].data);
      checkOutput($sformatf("t3_count_%0d", i), 32'(fifo_count), 32'(full_vecs[i].exp_count));
      checkOutput($sformatf("t3_full_%0d", i), 32'(fifo_full), 32'(full_vecs[i].exp_full));
    end
    checkOutput("t3_no_start", start_log.size() - base, 0);
`ifdef UART_FIFO_OVF_EN
    checkOutput("t3_ovf_sticky", 32'(ovf_sticky), 1);
    checkOutput("t3_ovf_cnt", 32'(ovf_cnt), 2);
`endif
    force_busy = 1'b0;
    wait_log(base + 16, 2000);
    repeat (60) @(negedge clk);
    checkOutput("t3_drain_count", start_log.size() - base, 16);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("t3_order_%0d", i), 32'(log_at(base + i)), 32'(full_vecs[i].data));
    end
    checkOutput("t3_empty_final", 32'(fifo_empty), 1);

    // Pointer wrap, then push and pop on the same edge while full
    do_reset();
    force_busy = 1'b1;
    base = start_log.size();
    for (int i = 0; i < 12; i++) applyStimulus(8'(8'hA0 + i));
    force_busy = 1'b0;
    wait_log(base + 12, 2000);
    repeat (30) @(negedge clk);
    checkOutput("t4_first_drain", start_log.size() - base, 12);
    checkOutput("t4_first_last", 32'(log_at(base + 11)), 32'hAB);
    force_busy = 1'b1;
    base = start_log.size();
    for (int i = 0; i < 16; i++) applyStimulus(8'(8'hB0 + i));
    checkOutput("t4_full_count", 32'(fifo_count), 16);
    checkOutput("t4_full_flag", 32'(fifo_full), 1);
    @(negedge clk);
    rx_data = 8'hD5;
    rx_int  = 1'b1;
    repeat (10) @(negedge clk);
    rx_int = 1'b0;
    force_busy = 1'b0;
    @(negedge clk);
    checkOutput("t4_simul_count", 32'(fifo_count), 16);
    checkOutput("t4_simul_full", 32'(fifo_full), 1);
    wait_log(base + 17, 3000);
    repeat (30) @(negedge clk);
    checkOutput("t4_drain_count", start_log.size() - base, 17);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("t4_order_%0d", i), 32'(log_at(base + i)), 32'(8'hB0 + i));
    end
    checkOutput("t4_order_last", 32'(log_at(base + 16)), 32'hD5);

    // Reset while a frame is in flight
    do_reset();
    busy_len = 100;
    force_busy = 1'b1;
    base = start_log.size();
    applyStimulus(8'hC1);
    applyStimulus(8'hC2);
    applyStimulus(8'hC3);
    force_busy = 1'b0;
    wait_log(base + 1, 50);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("t5_count", 32'(fifo_count), 0);
    checkOutput("t5_tx_start", 32'(tx_start), 0);
    checkOutput("t5_tx_data", 32'(tx_data), 0);
    checkOutput("t5_empty", 32'(fifo_empty), 1);
    repeat (150) @(negedge clk);
    checkOutput("t5_start_count", start_log.size() - base, 1);

    // Transmitter never raises busy: 65536 WAIT_HI cycles, then IDLE and START
    do_reset();
    model_en = 1'b0;
    force_busy = 1'b1;
    base = start_log.size();
    applyStimulus(8'hE1);
    applyStimulus(8'hE2);
    force_busy = 1'b0;
    wait_log(base + 2, 70000);
    checkOutput("t6_start_count", start_log.size() - base, 2);
    gap = (start_cyc.size() >= base + 2) ? start_cyc[base + 1] - start_cyc[base] : -1;
    checkOutput("t6_gap", gap, 65538);
    checkOutput("t6_data_0", 32'(log_at(base)), 32'hE1);
    checkOutput("t6_data_1", 32'(log_at(base + 1)), 32'hE2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
